transpose_sequencer: RTL and testbench

- Controller that sequences one square-matrix transpose job: LOAD, then TRANSPOSE, then SEND.
- Accepts a runtime dimension (1..MAX_DIM) and takes row-major elements from the host over a valid/ready stream.
- Buffers the elements, then streams them back in transposed order over a second valid/ready stream.
- Reports a saturating cycle count for the job. Sits between the host-side register interface and the matrix buffer, replacing ad-hoc index-driven load/readout.

---
 rtl/transpose_sequencer_pkg.sv | 24 ++
 rtl/transpose_sequencer_xpose_buf.sv | 29 ++
 rtl/transpose_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_transpose_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/transpose_sequencer_pkg.sv
// Shared definitions for the transpose sequencer: default sizes, index width,
// state encoding and the dimension legality check.
package transpose_sequencer_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int MAX_DIM_DEF = 5;
  localparam int CNT_W_DEF   = 10;
  localparam int DIM_W       = 3;
  localparam int IDX_W       = $clog2(MAX_DIM_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_XPOSE = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A dimension is usable when it is non-zero and fits the buffer.
  function automatic logic dim_legal(input logic [DIM_W-1:0] d, input int max_dim);
    return (d != 3'd0) && (int'({29'd0, d}) <= max_dim);
  endfunction

endpackage

// File: rtl/transpose_sequencer_xpose_buf.sv
// Square element store for one job: synchronous write, asynchronous read,
// no reset because contents are always rewritten before being read.
module xpose_buf #(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 5,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [IDX_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_row,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [MAX_DIM][MAX_DIM];

  // Element write on host accept
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_row][rd_col];

endmodule

// File: rtl/transpose_sequencer.sv
// Sequences one square-matrix transpose job: row-major load, one turnaround
// cycle, transposed send, completion pulse and saturating cycle count.
module transpose_sequencer
  import transpose_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        dim,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  cycles
);

  state_t              state_r;
  logic [DIM_W-1:0]    dim_r;
  logic [IDX_W-1:0]    row_r;
  logic [IDX_W-1:0]    col_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                busy_r;
  logic                done_r;
  logic                cfg_err_r;
  logic [CNT_W-1:0]    cycles_r;

  logic [DIM_W-1:0]    dim_m1_s;
  logic                last_col_s;
  logic                last_row_s;
  logic                last_elem_s;
  logic [IDX_W-1:0]    next_row_s;
  logic [IDX_W-1:0]    next_col_s;
  logic [IDX_W-1:0]    rd_row_s;
  logic [IDX_W-1:0]    rd_col_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic [CNT_W-1:0]    cycles_inc_s;
  logic                in_fire_s;
  logic                out_fire_s;
  logic                dim_ok_s;

  assign in_fire_s  = in_valid && in_ready_r;
  assign out_fire_s = out_ready && out_valid_r;
  assign dim_ok_s   = dim_legal(dim, MAX_DIM);

  // Index stepping, look-ahead read address and saturating count increment
  always_comb begin
    dim_m1_s    = dim_r - 3'd1;
    last_col_s  = (col_r == dim_m1_s[IDX_W-1:0]);
    last_row_s  = (row_r == dim_m1_s[IDX_W-1:0]);
    last_elem_s = last_col_s && last_row_s;
    if (last_col_s) begin
      next_col_s = '0;
      next_row_s = row_r + IDX_W'(1);
    end else begin
      next_col_s = col_r + IDX_W'(1);
      next_row_s = row_r;
    end
    // Output (i,j) is stored at [j][i]; in SEND fetch the element after the current one
    if (state_r == ST_SEND) begin
      rd_row_s = next_col_s;
      rd_col_s = next_row_s;
    end else begin
      rd_row_s = '0;
      rd_col_s = '0;
    end
    if (cycles_r == {CNT_W{1'b1}}) begin
      cycles_inc_s = cycles_r;
    end else begin
      cycles_inc_s = cycles_r + CNT_W'(1);
    end
  end

  xpose_buf #(
    .DATA_W  (DATA_W),
    .MAX_DIM (MAX_DIM),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (in_fire_s),
    .wr_row  (row_r),
    .wr_col  (col_r),
    .wr_data (in_data),
    .rd_row  (rd_row_s),
    .rd_col  (rd_col_s),
    .rd_data (rd_data_s)
  );

  // Job FSM with registered handshake, status and counter outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      dim_r       <= 3'd0;
      row_r       <= '0;
      col_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      cycles_r    <= '0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (dim_ok_s) begin
              dim_r      <= dim;
              cycles_r   <= '0;
              row_r      <= '0;
              col_r      <= '0;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= ST_LOAD;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          cycles_r <= cycles_inc_s;
          if (in_fire_s) begin
            row_r <= next_row_s;
            col_r <= next_col_s;
            if (last_elem_s) begin
              in_ready_r <= 1'b0;
              state_r    <= ST_XPOSE;
            end
          end
        end
        ST_XPOSE: begin
          // Read address is [0][0] here, so the first transposed element is ready
          cycles_r    <= cycles_inc_s;
          row_r       <= '0;
          col_r       <= '0;
          out_valid_r <= 1'b1;
          out_data_r  <= rd_data_s;
          state_r     <= ST_SEND;
        end
        ST_SEND: begin
          cycles_r <= cycles_inc_s;
          if (out_fire_s) begin
            if (last_elem_s) begin
              out_valid_r <= 1'b0;
              out_data_r  <= '0;
              done_r      <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              row_r      <= next_row_s;
              col_r      <= next_col_s;
              out_data_r <= rd_data_s;
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;
  assign cycles    = cycles_r;

endmodule

// File: tb/tb_transpose_sequencer.sv
// Scoreboard bench: a 10-bit-counter and a 4-bit-counter instance run in lockstep
// against a matrix-level model of transposed output order and job cycle count.
module tb_transpose_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    dim;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready, out_valid, busy, done, cfg_err;
  logic [DW-1:0] out_data;
  logic [9:0]    cycles;
  logic          in_ready4, out_valid4, busy4, done4, cfg_err4;
  logic [DW-1:0] out_data4;
  logic [3:0]    cycles4;

  int            vectors = 0;
  int            errors  = 0;
  int            last_cyc = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  transpose_sequencer #(.DATA_W(DW), .MAX_DIM(5), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .dim(dim),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err), .cycles(cycles)
  );

  transpose_sequencer #(.DATA_W(DW), .MAX_DIM(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .dim(dim),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .busy(busy4), .done(done4), .cfg_err(cfg_err4), .cycles(cycles4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // Output monitor: head of the queue must be presented while valid, popped on accept
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid || out_valid4) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL out_extra: got %0h expected no output", out_data);
        end else begin
          check("out_valid_pair", {out_valid, out_valid4}, 2'b11);
          check("out_data", out_data, exp_q[0]);
          check("out_data_cnt4", out_data4, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_data_zero", {out_data, out_data4}, 64'd0);
      end
    end
  end

  task automatic run_job(input int d, input int fill, input int imode, input int omode,
                         input bit poke, input int abort_after);
    logic [DW-1:0] a [5][5];
    int lc, sc, n, m, ec;
    bit v, r;
    for (int k = 0; k < d * d; k++) a[k / d][k % d] = (fill == 0) ? $urandom : DW'(fill * (k + 1));
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++) exp_q.push_back(a[j][i]);
    start = 1'b1;
    dim   = 3'(d);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; lc = 0;
    while (n < d * d) begin
      case (imode)
        0:       v = 1'b1;
        1:       v = (lc % 2 == 0);
        2:       v = ($urandom_range(0, 2) != 0);
        3:       v = (lc >= 20);
        default: v = 1'b1;
      endcase
      in_valid = v;
      in_data  = v ? a[n / d][n % d] : $urandom;
      if (poke && lc == 1) begin
        start = 1'b1;
        dim   = 3'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("load_flags", {in_ready, in_ready4, busy, busy4, cfg_err, cfg_err4}, 6'b111100);
      @(posedge clk); #1;
      lc++;
      if (v) n++;
      if (lc > 500) begin
        check("load_timeout", 64'(n), 64'(d * d));
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    check("xpose_flags", {in_ready, in_ready4, out_valid, out_valid4, busy, busy4}, 6'b000011);
    @(posedge clk); #1;
    m = 0; sc = 0;
    while (m < d * d) begin
      case (omode)
        0:       r = 1'b1;
        1:       r = (sc % 2 == 0);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      out_ready = r;
      @(negedge clk);
      check("send_flags", {out_valid, out_valid4, busy, busy4, done, done4}, 6'b111100);
      @(posedge clk); #1;
      sc++;
      if (r) m++;
      if (abort_after >= 0 && m == abort_after) begin
        #2 reset = 1'b0;
        #1;
        check("abort_outputs", {in_ready, out_valid, busy, done, cfg_err, cycles}, 64'd0);
        check("abort_data", {out_data, out_data4}, 64'd0);
        check("abort_outputs4", {in_ready4, out_valid4, busy4, done4, cfg_err4, cycles4}, 64'd0);
        exp_q.delete();
        out_ready = 1'b0;
        last_cyc  = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        return;
      end
      if (sc > 500) begin
        check("send_timeout", 64'(m), 64'(d * d));
        break;
      end
    end
    out_ready = 1'b0;
    ec = lc + 1 + sc;
    @(negedge clk);
    check("done_pulse", {done, done4, busy, busy4}, 4'hF);
    check("cycles", cycles, 64'(sat(ec, 1023)));
    check("cycles_sat4", cycles4, 64'(sat(ec, 15)));
    @(negedge clk);
    check("after_done", {done, done4, busy, busy4}, 4'h0);
    check("cycles_hold", cycles, 64'(sat(ec, 1023)));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    last_cyc = sat(ec, 1023);
  endtask

  task automatic bad_start(input int d);
    start = 1'b1;
    dim   = 3'(d);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", {cfg_err, cfg_err4, busy, busy4}, 4'b1100);
    check("cycles_unchanged", cycles, 64'(last_cyc));
    @(negedge clk);
    check("cfg_err_once", {cfg_err, cfg_err4, busy, busy4}, 4'b0000);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dim = 3'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {in_ready, out_valid, busy, done, cfg_err, cycles}, 64'd0);
    check("reset_flags4", {in_ready4, out_valid4, busy4, done4, cfg_err4, cycles4}, 64'd0);
    check("reset_data", {out_data, out_data4}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    run_job(5, 1, 0, 0, 1'b0, -1);
    run_job(2, 10, 0, 0, 1'b0, -1);
    run_job(3, 1, 1, 1, 1'b0, -1);
    bad_start(0);
    bad_start(6);
    bad_start(7);
    run_job(3, 0, 0, 0, 1'b1, -1);
    run_job(4, 0, 0, 0, 1'b0, 3);
    run_job(1, 42, 0, 0, 1'b0, -1);
    run_job(3, 0, 3, 0, 1'b0, -1);
    for (int t = 0; t < 8; t++) run_job($urandom_range(1, 5), 0, 2, 2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
